rx_stream_arbiter: RTL and testbench
====================================

RX_STREAM_ARBITER -- requirements
Module: rx_stream_arbiter

Interface
REQ-001 Parameter: CNT_WIDTH, default 16, width of the per-channel accepted-sample counters.
REQ-002 s0_axi_aclk  in  1  sole clock; all logic rising-edge.
REQ-003 s0_axi_aresetn  in  1  synchronous, active-low reset.
REQ-004 en_i  in  1  arbitration enable; low blocks new grants.
REQ-005 prio_mode_i  in  1  0 = round-robin, 1 = fixed priority to rx0.
REQ-006 clear_i  in  1  synchronous counter clear.
REQ-007 rx0_axis_tdata_i  in  64  rx0 chain sample; rx0_axis_tvalid_i  in  1; rx0_axis_tready_o  out  1.
REQ-008 rx1_axis_tdata_i  in  64  rx1 chain sample; rx1_axis_tvalid_i  in  1; rx1_axis_tready_o  out  1.
REQ-009 m_axis_tdata_o  out  32  merged output word.
REQ-010 m_axis_tuser_o  out  1  source channel of current word (0 = rx0, 1 = rx1).
REQ-011 m_axis_tlast_o  out  1  high on the second (upper) word of a sample.
REQ-012 m_axis_tvalid_o  out  1; m_axis_tready_i  in  1  AXI-stream handshake.
REQ-013 rx0_count_o, rx1_count_o  out  CNT_WIDTH  accepted-sample counts.
REQ-014 busy_o  out  1  high when state is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, LO and HI.
REQ-016 The grant SHALL be computed combinationally from the tvalid inputs, prio_mode_i and last_grant.
REQ-017 Grant, fixed mode: rx0 if rx0 valid, else rx1 if rx1 valid.
REQ-018 Grant, round-robin mode: if both channels are valid, grant the channel != last_grant; if only one is valid, grant it.
REQ-019 rxN_axis_tready_o SHALL be high only when en_i=1 and N is the grant, and the state is either:
- IDLE, or
- HI with m_axis_tready_i=1.
REQ-020 On an input handshake, the block SHALL:
- register the 64-bit sample and the channel;
- set last_grant to that channel;
- enter LO on the next cycle.
REQ-021 LO: m_axis_tvalid_o=1, tdata = sample[31:0], tlast=0, tuser = channel; on m_axis_tready_i go to HI.
REQ-022 HI: m_axis_tvalid_o=1, tdata = sample[63:32], tlast=1, same tuser.
REQ-023 Leaving HI on m_axis_tready_i: go to LO if a new sample was accepted in the same cycle, else to IDLE.
REQ-024 Throughput SHALL be one sample per 2 cycles when sources are valid and the sink is always ready.
REQ-025 Latency from input handshake to the first output word valid SHALL be 1 cycle.
REQ-026 The output SHALL hold tdata, tuser and tlast stable while tvalid=1 and tready=0.
REQ-027 en_i deasserted mid-sample SHALL NOT abort the sample; LO/HI complete, then the FSM stays in IDLE.
REQ-028 Changing prio_mode_i SHALL take effect on the next grant evaluation only.
REQ-029 rxN_count_o SHALL increment by 1 per rxN input handshake and saturate at 2^CNT_WIDTH-1.
REQ-030 clear_i SHALL zero both counters and takes priority over a same-cycle increment.
REQ-031 At most one rx tready SHALL be high in any cycle.

Reset
REQ-032 While s0_axi_aresetn=0 at a clock edge, the block SHALL set:
- state = IDLE, last_grant = 1 (so rx0 wins the first round-robin tie);
- all tready and tvalid outputs = 0;
- m_axis_tdata_o = 0, tuser = 0, tlast = 0;
- both counters = 0, busy_o = 0.
REQ-033 Reset asserted mid-sample SHALL discard the captured sample with no partial output afterwards.
REQ-034 Outputs SHALL be registered or decoded from registered state only, except tready per REQ-019.

Verification
REQ-035 Single source: rx0 valid with 0x11112222_33334444, sink ready -> words 0x33334444 (tlast 0), then 0x11112222 (tlast 1), tuser 0, rx0_count_o=1.
REQ-036 Round-robin, both channels always valid, sink ready, 8 samples -> tuser sequence 0,0,1,1,0,0,1,1... at word level; each count=4; one sample every 2 cycles.
REQ-037 Fixed priority, both valid for 6 samples -> all tuser=0, rx1_count_o=0, rx1 tready never high.
REQ-038 Sink stalls 3 cycles in LO -> tdata/tuser/tlast unchanged, no input accepted, then HI then IDLE.
REQ-039 en_i drops in the LO cycle -> HI still emitted, no new tready, busy_o falls after the HI handshake.
REQ-040 Counter boundaries:
- CNT_WIDTH=2 with 5 rx1 samples -> rx1_count_o saturates at 3;
- clear_i with a simultaneous handshake -> count 0.
- reset asserted in HI -> next cycle tvalid=0, busy_o=0.

Source files
------------

// File: rtl/rx_stream_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// rx_stream_arbiter
// Merges two 64-bit receive-chain sample streams (rx0, rx1) into a single
// 32-bit AXI-stream. Each accepted sample is emitted as two words: the lower
// half first (tlast=0), then the upper half (tlast=1). tuser carries the
// source channel. Arbitration is either fixed priority to rx0 or round-robin.
//
// Ports:
//   s0_axi_aclk        clock, rising edge
//   s0_axi_aresetn     synchronous active-low reset
//   en_i               arbitration enable (low blocks new grants only)
//   prio_mode_i        0 = round-robin, 1 = fixed priority to rx0
//   clear_i            synchronous clear of both sample counters
//   rxN_axis_*         64-bit input sample streams (tdata/tvalid/tready)
//   m_axis_*           32-bit merged output stream (tdata/tuser/tlast/tvalid/tready)
//   rx0_count_o/rx1_count_o  saturating accepted-sample counters
//   busy_o             high while a sample is being emitted
// ---------------------------------------------------------------------------
module rx_stream_arbiter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 s0_axi_aclk,
  input  logic                 s0_axi_aresetn,
  input  logic                 en_i,
  input  logic                 prio_mode_i,
  input  logic                 clear_i,
  input  logic [63:0]          rx0_axis_tdata_i,
  input  logic                 rx0_axis_tvalid_i,
  output logic                 rx0_axis_tready_o,
  input  logic [63:0]          rx1_axis_tdata_i,
  input  logic                 rx1_axis_tvalid_i,
  output logic                 rx1_axis_tready_o,
  output logic [31:0]          m_axis_tdata_o,
  output logic                 m_axis_tuser_o,
  output logic                 m_axis_tlast_o,
  output logic                 m_axis_tvalid_o,
  input  logic                 m_axis_tready_i,
  output logic [CNT_WIDTH-1:0] rx0_count_o,
  output logic [CNT_WIDTH-1:0] rx1_count_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [63:0]          sample_q, sample_d;
  logic                 chan_q, chan_d;
  logic                 lastGrant_q, lastGrant_d;
  logic [CNT_WIDTH-1:0] rx0Count_q, rx0Count_d;
  logic [CNT_WIDTH-1:0] rx1Count_q, rx1Count_d;

  logic anyValid;
  logic grant;
  logic canAccept;
  logic inHandshake;

  // Grant selection. With only one channel valid (or in fixed mode) rx0 wins
  // whenever it is valid; on a round-robin tie the channel that did not win
  // last time is chosen. When nothing is valid the grant is irrelevant
  // because inHandshake is gated by anyValid.
  always_comb begin
    anyValid = rx0_axis_tvalid_i | rx1_axis_tvalid_i;
    if (prio_mode_i || !(rx0_axis_tvalid_i && rx1_axis_tvalid_i)) begin
      grant = ~rx0_axis_tvalid_i;
    end else begin
      grant = ~lastGrant_q;
    end
  end

  // A new sample can be taken when idle, or in the cycle the upper word
  // leaves, which gives back-to-back samples at one per two cycles. Reset
  // gates the readies so nothing is offered while the block is being reset.
  always_comb begin
    canAccept   = s0_axi_aresetn && en_i &&
                  ((state_q == IDLE) || ((state_q == HI) && m_axis_tready_i));
    inHandshake = canAccept && anyValid;
    rx0_axis_tready_o = inHandshake && !grant;
    rx1_axis_tready_o = inHandshake &&  grant;
  end

  // Next-state logic for the word sequencer and the captured sample.
  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    chan_d      = chan_q;
    lastGrant_d = lastGrant_q;

    case (state_q)
      IDLE: begin
        if (inHandshake) state_d = LO;
      end
      LO: begin
        if (m_axis_tready_i) state_d = HI;
      end
      HI: begin
        if (m_axis_tready_i) state_d = inHandshake ? LO : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (inHandshake) begin
      sample_d    = grant ? rx1_axis_tdata_i : rx0_axis_tdata_i;
      chan_d      = grant;
      lastGrant_d = grant;
    end
  end

  // Saturating per-channel sample counters; clear wins over an increment.
  always_comb begin
    rx0Count_d = rx0Count_q;
    rx1Count_d = rx1Count_q;
    if (clear_i) begin
      rx0Count_d = '0;
      rx1Count_d = '0;
    end else if (inHandshake) begin
      if (!grant && (rx0Count_q != {CNT_WIDTH{1'b1}})) begin
        rx0Count_d = rx0Count_q + CNT_WIDTH'(1);
      end
      if (grant && (rx1Count_q != {CNT_WIDTH{1'b1}})) begin
        rx1Count_d = rx1Count_q + CNT_WIDTH'(1);
      end
    end
  end

  // State registers. lastGrant resets to rx1 so rx0 wins the first tie.
  always_ff @(posedge s0_axi_aclk) begin
    if (!s0_axi_aresetn) begin
      state_q     <= IDLE;
      sample_q    <= '0;
      chan_q      <= 1'b0;
      lastGrant_q <= 1'b1;
      rx0Count_q  <= '0;
      rx1Count_q  <= '0;
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      chan_q      <= chan_d;
      lastGrant_q <= lastGrant_d;
      rx0Count_q  <= rx0Count_d;
      rx1Count_q  <= rx1Count_d;
    end
  end

  // Outputs decoded purely from registered state, so they stay stable while
  // the sink stalls.
  always_comb begin
    m_axis_tvalid_o = (state_q != IDLE);
    m_axis_tlast_o  = (state_q == HI);
    m_axis_tuser_o  = (state_q != IDLE) && chan_q;
    case (state_q)
      LO:      m_axis_tdata_o = sample_q[31:0];
      HI:      m_axis_tdata_o = sample_q[63:32];
      default: m_axis_tdata_o = '0;
    endcase
    busy_o      = (state_q != IDLE);
    rx0_count_o = rx0Count_q;
    rx1_count_o = rx1Count_q;
  end

endmodule

// File: tb/tb_rx_stream_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_rx_stream_arbiter
// Self-checking bench: a table of directed vectors, hand-written sequences for
// round-robin, fixed priority and counter saturation, and randomized traffic
// compared against a word-queue reference model.
// ---------------------------------------------------------------------------
module tb_rx_stream_arbiter;

  localparam logic [63:0] SA = 64'h11112222_33334444;
  localparam logic [63:0] SB = 64'hAAAABBBB_CCCCDDDD;
  localparam logic [63:0] SC = 64'h01234567_89ABCDEF;

  logic        clk = 1'b0;
  logic        rstn, en, prio, clr;
  logic [63:0] d0, d1;
  logic        v0, v1, mrdy;

  logic        rdy0, rdy1, mValid, mUser, mLast, busy;
  logic [31:0] mData;
  logic [15:0] cnt0, cnt1;

  logic        s_rdy0, s_rdy1, s_mValid, s_mUser, s_mLast, s_busy;
  logic [31:0] s_mData;
  logic [1:0]  s_cnt0, s_cnt1;

  int passCnt  = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  rx_stream_arbiter #(.CNT_WIDTH(16)) dut (
    .s0_axi_aclk(clk), .s0_axi_aresetn(rstn), .en_i(en), .prio_mode_i(prio),
    .clear_i(clr),
    .rx0_axis_tdata_i(d0), .rx0_axis_tvalid_i(v0), .rx0_axis_tready_o(rdy0),
    .rx1_axis_tdata_i(d1), .rx1_axis_tvalid_i(v1), .rx1_axis_tready_o(rdy1),
    .m_axis_tdata_o(mData), .m_axis_tuser_o(mUser), .m_axis_tlast_o(mLast),
    .m_axis_tvalid_o(mValid), .m_axis_tready_i(mrdy),
    .rx0_count_o(cnt0), .rx1_count_o(cnt1), .busy_o(busy)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  rx_stream_arbiter #(.CNT_WIDTH(2)) dutSmall (
    .s0_axi_aclk(clk), .s0_axi_aresetn(rstn), .en_i(en), .prio_mode_i(prio),
    .clear_i(clr),
    .rx0_axis_tdata_i(d0), .rx0_axis_tvalid_i(v0), .rx0_axis_tready_o(s_rdy0),
    .rx1_axis_tdata_i(d1), .rx1_axis_tvalid_i(v1), .rx1_axis_tready_o(s_rdy1),
    .m_axis_tdata_o(s_mData), .m_axis_tuser_o(s_mUser), .m_axis_tlast_o(s_mLast),
    .m_axis_tvalid_o(s_mValid), .m_axis_tready_i(mrdy),
    .rx0_count_o(s_cnt0), .rx1_count_o(s_cnt1), .busy_o(s_busy)
  );

  typedef struct {
    logic        rstn, en, prio, clr, v0;
    logic [63:0] d0;
    logic        v1;
    logic [63:0] d1;
    logic        mrdy;
    logic        care;
    logic        eValid;
    logic [31:0] eData;
    logic        eUser, eLast, eRdy0, eRdy1, eBusy;
    int          eCnt0, eCnt1;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        user;
    logic        last;
  } word_t;

  vec_t vecs[25];

  // Inputs change at the falling edge; outputs are sampled 1ns later.
  task automatic applyStimulus(input logic iRstn, input logic iEn, input logic iPrio,
                               input logic iClr, input logic iV0, input logic [63:0] iD0,
                               input logic iV1, input logic [63:0] iD1, input logic iMrdy);
    @(negedge clk);
    rstn = iRstn; en = iEn; prio = iPrio; clr = iClr;
    v0 = iV0; d0 = iD0; v1 = iV1; d1 = iD1; mrdy = iMrdy;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference grant rule: fixed mode or single valid -> rx0 if valid, else rx1;
  // round-robin tie -> the channel that did not win last time.
  function automatic logic refGrant(input logic p, input logic a, input logic b, input logic lastG);
    if (a && b && !p) return !lastG;
    return !a;
  endfunction

  initial begin
    logic  usersQ[$];
    int    validCycles, rdy1Seen, nonZeroUsers, handshakes;
    word_t wq[$];
    word_t w;
    logic  mLastG;
    int    mC0, mC1, mC1s;

    rstn = 0; en = 0; prio = 0; clr = 0; v0 = 0; v1 = 0; d0 = '0; d1 = '0; mrdy = 0;

    vecs[0]  = '{0,1,0,0,1,SA,0,0,1,  1,0,32'h0,0,0,0,0,0,0,0};
    vecs[1]  = '{1,1,0,0,1,SA,0,0,1,  0,0,32'h0,0,0,1,0,0,0,0};
    vecs[2]  = '{1,1,0,0,0,0,0,0,1,   1,1,32'h33334444,0,0,0,0,1,1,0};
    vecs[3]  = '{1,1,0,0,0,0,0,0,1,   1,1,32'h11112222,0,1,0,0,1,1,0};
    vecs[4]  = '{1,1,0,0,0,0,0,0,1,   0,0,32'h0,0,0,0,0,0,1,0};
    vecs[5]  = '{1,1,0,0,0,0,1,SB,0,  0,0,32'h0,0,0,0,1,0,1,0};
    vecs[6]  = '{1,1,0,0,0,0,1,SC,0,  1,1,32'hCCCCDDDD,1,0,0,0,1,1,1};
    vecs[7]  = '{1,1,0,0,0,0,1,SC,0,  1,1,32'hCCCCDDDD,1,0,0,0,1,1,1};
    vecs[8]  = '{1,1,0,0,0,0,1,SC,0,  1,1,32'hCCCCDDDD,1,0,0,0,1,1,1};
    vecs[9]  = '{1,1,0,0,0,0,1,SC,1,  1,1,32'hCCCCDDDD,1,0,0,0,1,1,1};
    vecs[10] = '{1,1,0,0,0,0,0,0,1,   1,1,32'hAAAABBBB,1,1,0,0,1,1,1};
    vecs[11] = '{1,1,0,0,0,0,0,0,1,   0,0,32'h0,0,0,0,0,0,1,1};
    vecs[12] = '{1,1,0,0,1,SC,0,0,1,  0,0,32'h0,0,0,1,0,0,1,1};
    vecs[13] = '{1,0,0,0,1,SA,1,SB,1, 1,1,32'h89ABCDEF,0,0,0,0,1,2,1};
    vecs[14] = '{1,0,0,0,1,SA,1,SB,1, 1,1,32'h01234567,0,1,0,0,1,2,1};
    vecs[15] = '{1,0,0,0,1,SA,1,SB,1, 0,0,32'h0,0,0,0,0,0,2,1};
    vecs[16] = '{1,1,0,1,1,SA,1,SB,1, 0,0,32'h0,0,0,0,1,0,2,1};
    vecs[17] = '{1,1,0,0,0,0,0,0,1,   1,1,32'hCCCCDDDD,1,0,0,0,1,0,0};
    vecs[18] = '{0,1,0,0,0,0,0,0,1,   1,1,32'hAAAABBBB,1,1,0,0,1,0,0};
    vecs[19] = '{1,1,0,0,0,0,0,0,1,   1,0,32'h0,0,0,0,0,0,0,0};
    vecs[20] = '{1,1,0,0,0,0,0,0,1,   1,0,32'h0,0,0,0,0,0,0,0};
    vecs[21] = '{1,1,0,0,1,SA,1,SB,1, 0,0,32'h0,0,0,1,0,0,0,0};
    vecs[22] = '{1,1,0,0,0,0,0,0,1,   1,1,32'h33334444,0,0,0,0,1,1,0};
    vecs[23] = '{1,1,0,0,0,0,0,0,1,   1,1,32'h11112222,0,1,0,0,1,1,0};
    vecs[24] = '{1,1,0,0,0,0,0,0,1,   0,0,32'h0,0,0,0,0,0,1,0};

    // Directed table
    applyStimulus(0,0,0,0,0,0,0,0,0);
    applyStimulus(0,0,0,0,0,0,0,0,0);
    for (int i = 0; i < 25; i++) begin
      applyStimulus(vecs[i].rstn, vecs[i].en, vecs[i].prio, vecs[i].clr, vecs[i].v0,
                    vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].mrdy);
      checkOutput($sformatf("row%0d_tvalid", i), 64'(mValid), 64'(vecs[i].eValid));
      checkOutput($sformatf("row%0d_rdy0", i), 64'(rdy0), 64'(vecs[i].eRdy0));
      checkOutput($sformatf("row%0d_rdy1", i), 64'(rdy1), 64'(vecs[i].eRdy1));
      checkOutput($sformatf("row%0d_busy", i), 64'(busy), 64'(vecs[i].eBusy));
      checkOutput($sformatf("row%0d_cnt0", i), 64'(cnt0), 64'(vecs[i].eCnt0));
      checkOutput($sformatf("row%0d_cnt1", i), 64'(cnt1), 64'(vecs[i].eCnt1));
      if (vecs[i].care) begin
        checkOutput($sformatf("row%0d_tdata", i), 64'(mData), 64'(vecs[i].eData));
        checkOutput($sformatf("row%0d_tuser", i), 64'(mUser), 64'(vecs[i].eUser));
        checkOutput($sformatf("row%0d_tlast", i), 64'(mLast), 64'(vecs[i].eLast));
      end
    end

    // Round-robin, both channels valid, 8 samples
    applyStimulus(0,0,0,0,0,0,0,0,1);
    validCycles = 0;
    handshakes  = 0;
    usersQ.delete();
    for (int c = 0; c <= 16; c++) begin
      applyStimulus(1,1,0,0,(c <= 14),SA,(c <= 14),SB,1);
      if (mValid) begin
        validCycles++;
        usersQ.push_back(mUser);
      end
      if (rdy0 || rdy1) begin
        handshakes++;
        checkOutput($sformatf("rr_accept_cycle%0d_even", c), 64'(c % 2), 64'(0));
      end
    end
    applyStimulus(1,1,0,0,0,0,0,0,1);
    checkOutput("rr_words", 64'(usersQ.size()), 64'(16));
    checkOutput("rr_valid_cycles", 64'(validCycles), 64'(16));
    checkOutput("rr_handshakes", 64'(handshakes), 64'(8));
    for (int k = 0; k < usersQ.size() && k < 16; k++)
      checkOutput($sformatf("rr_tuser_word%0d", k), 64'(usersQ[k]), 64'((k / 2) % 2));
    checkOutput("rr_cnt0", 64'(cnt0), 64'(4));
    checkOutput("rr_cnt1", 64'(cnt1), 64'(4));
    checkOutput("rr_busy_end", 64'(busy), 64'(0));

    // Fixed priority, both channels valid, 6 samples
    applyStimulus(0,0,1,0,0,0,0,0,1);
    rdy1Seen = 0;
    nonZeroUsers = 0;
    usersQ.delete();
    for (int c = 0; c <= 12; c++) begin
      applyStimulus(1,1,1,0,(c <= 10),SA,(c <= 10),SB,1);
      if (rdy1) rdy1Seen++;
      if (mValid) begin
        usersQ.push_back(mUser);
        if (mUser) nonZeroUsers++;
      end
    end
    applyStimulus(1,1,1,0,0,0,0,0,1);
    checkOutput("fix_words", 64'(usersQ.size()), 64'(12));
    checkOutput("fix_tuser_nonzero", 64'(nonZeroUsers), 64'(0));
    checkOutput("fix_rdy1_seen", 64'(rdy1Seen), 64'(0));
    checkOutput("fix_cnt0", 64'(cnt0), 64'(6));
    checkOutput("fix_cnt1", 64'(cnt1), 64'(0));

    // Saturation: 5 rx1 samples into a 2-bit counter
    applyStimulus(0,0,0,0,0,0,0,0,1);
    for (int c = 0; c <= 10; c++)
      applyStimulus(1,1,0,0,0,0,(c <= 8),SB,1);
    applyStimulus(1,1,0,0,0,0,0,0,1);
    checkOutput("sat_wide_cnt1", 64'(cnt1), 64'(5));
    checkOutput("sat_narrow_cnt1", 64'(s_cnt1), 64'(3));

    // Randomized traffic against the word-queue model
    applyStimulus(0,0,0,0,0,0,0,0,0);
    wq.delete();
    mLastG = 1'b1;
    mC0 = 0; mC1 = 0; mC1s = 0;
    prio = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        r_rstn, r_en, r_prio, r_clr, r_v0, r_v1, r_mrdy;
      logic [63:0] r_d0, r_d1;
      logic        eValid, canAcc, g, eRdy0, eRdy1;
      r_rstn = ($urandom_range(0, 199) != 0);
      r_en   = ($urandom_range(0, 7) != 0);
      r_prio = ($urandom_range(0, 29) == 0) ? ~prio : prio;
      r_clr  = ($urandom_range(0, 49) == 0);
      r_v0   = $urandom_range(0, 1) == 1;
      r_v1   = $urandom_range(0, 1) == 1;
      r_d0   = {$urandom, $urandom};
      r_d1   = {$urandom, $urandom};
      r_mrdy = ($urandom_range(0, 3) != 0);
      applyStimulus(r_rstn, r_en, r_prio, r_clr, r_v0, r_d0, r_v1, r_d1, r_mrdy);

      eValid = (wq.size() > 0);
      canAcc = r_rstn && r_en && ((wq.size() == 0) || ((wq.size() == 1) && r_mrdy));
      g      = refGrant(r_prio, r_v0, r_v1, mLastG);
      eRdy0  = canAcc && r_v0 && !g;
      eRdy1  = canAcc && r_v1 && g;

      checkOutput($sformatf("rnd%0d_tvalid", cyc), 64'(mValid), 64'(eValid));
      checkOutput($sformatf("rnd%0d_busy", cyc), 64'(busy), 64'(eValid));
      checkOutput($sformatf("rnd%0d_rdy0", cyc), 64'(rdy0), 64'(eRdy0));
      checkOutput($sformatf("rnd%0d_rdy1", cyc), 64'(rdy1), 64'(eRdy1));
      checkOutput($sformatf("rnd%0d_cnt0", cyc), 64'(cnt0), 64'(mC0));
      checkOutput($sformatf("rnd%0d_cnt1", cyc), 64'(cnt1), 64'(mC1));
      checkOutput($sformatf("rnd%0d_cnt1_narrow", cyc), 64'(s_cnt1), 64'(mC1s));
      if (eValid) begin
        checkOutput($sformatf("rnd%0d_tdata", cyc), 64'(mData), 64'(wq[0].data));
        checkOutput($sformatf("rnd%0d_tuser", cyc), 64'(mUser), 64'(wq[0].user));
        checkOutput($sformatf("rnd%0d_tlast", cyc), 64'(mLast), 64'(wq[0].last));
      end

      // Advance the model across the coming rising edge
      if (!r_rstn) begin
        wq.delete();
        mLastG = 1'b1;
        mC0 = 0; mC1 = 0; mC1s = 0;
      end else begin
        if (eValid && r_mrdy) void'(wq.pop_front());
        if (eRdy0 || eRdy1) begin
          w.data = g ? r_d1[31:0] : r_d0[31:0];
          w.user = g; w.last = 1'b0;
          wq.push_back(w);
          w.data = g ? r_d1[63:32] : r_d0[63:32];
          w.last = 1'b1;
          wq.push_back(w);
          mLastG = g;
        end
        if (r_clr) begin
          mC0 = 0; mC1 = 0; mC1s = 0;
        end else if (eRdy0) begin
          if (mC0 < 65535) mC0++;
        end else if (eRdy1) begin
          if (mC1 < 65535) mC1++;
          if (mC1s < 3) mC1s++;
        end
      end
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
